// File: rtl/writeback_arbiter_if.sv
// Writeback arbiter bus: memory/ALU result inputs, register-file write port,
// and the operand forwarding lookups.
interface writeback_arbiter_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
);
    logic              mem_valid;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic              alu_valid;
    logic [ADDR_W-1:0] alu_addr;
    logic [DATA_W-1:0] alu_data;
    logic              alu_ready;
    logic              write_back;
    logic [ADDR_W-1:0] write_addr;
    logic [DATA_W-1:0] write_data;
    logic [ADDR_W-1:0] src_addr;
    logic [ADDR_W-1:0] dst_addr;
    logic              fwd_src_hit;
    logic              fwd_dst_hit;
    logic [DATA_W-1:0] fwd_src_data;
    logic [DATA_W-1:0] fwd_dst_data;
    logic [7:0]        stall_cnt;

    modport master (
        output mem_valid, mem_addr, mem_data, alu_valid, alu_addr, alu_data,
               src_addr, dst_addr,
        input  alu_ready, write_back, write_addr, write_data,
               fwd_src_hit, fwd_dst_hit, fwd_src_data, fwd_dst_data, stall_cnt
    );

    modport slave (
        input  mem_valid, mem_addr, mem_data, alu_valid, alu_addr, alu_data,
               src_addr, dst_addr,
        output alu_ready, write_back, write_addr, write_data,
               fwd_src_hit, fwd_dst_hit, fwd_src_data, fwd_dst_data, stall_cnt
    );
endinterface

// File: rtl/writeback_arbiter.sv
// Merges memory and ALU results onto one register-file write port. Memory
// never stalls; ALU results wait in a small circular buffer when they lose.
module writeback_arbiter #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3,
    parameter int DEPTH  = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    writeback_arbiter_if.slave bus
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [ADDR_W-1:0] buf_addr [DEPTH];
    logic [DATA_W-1:0] buf_data [DEPTH];
    logic [PTR_W-1:0]  head, tail;
    logic [CNT_W-1:0]  count;

    logic              wb_q;
    logic [ADDR_W-1:0] wa_q;
    logic [DATA_W-1:0] wd_q;
    logic [7:0]        stall_q;

    logic              ready, alu_acc, push, pop, stall;
    logic              sel_valid;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;

    function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Ready depends only on the registered count, never on alu_valid.
    assign ready   = (count < CNT_W'(DEPTH));
    assign alu_acc = bus.alu_valid && ready;
    assign stall   = bus.alu_valid && !ready;
    assign pop     = !bus.mem_valid && (count != '0);
    assign push    = alu_acc && (bus.mem_valid || (count != '0));

    always_comb begin
        sel_valid = 1'b0;
        sel_addr  = '0;
        sel_data  = '0;
        if (bus.mem_valid) begin
            sel_valid = 1'b1;
            sel_addr  = bus.mem_addr;
            sel_data  = bus.mem_data;
        end else if (count != '0) begin
            sel_valid = 1'b1;
            sel_addr  = buf_addr[head];
            sel_data  = buf_data[head];
        end else if (alu_acc) begin
            sel_valid = 1'b1;
            sel_addr  = bus.alu_addr;
            sel_data  = bus.alu_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_q    <= 1'b0;
            wa_q    <= '0;
            wd_q    <= '0;
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            stall_q <= '0;
        end else begin
            wb_q <= sel_valid;
            if (sel_valid) begin
                wa_q <= sel_addr;
                wd_q <= sel_data;
            end
            if (push) tail <= wrap_inc(tail);
            if (pop)  head <= wrap_inc(head);
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
            if (stall && stall_q != 8'hFF) stall_q <= stall_q + 1'b1;
        end
    end

    // Payload storage needs no reset; validity is carried by count.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_addr[tail] <= bus.alu_addr;
            buf_data[tail] <= bus.alu_data;
        end
    end

    logic              src_hit, dst_hit;
    logic [DATA_W-1:0] src_data, dst_data;
    logic [PTR_W-1:0]  idx;

    // Walk oldest to newest so the tail-most match wins over the output register.
    always_comb begin
        src_hit  = wb_q && (wa_q == bus.src_addr);
        dst_hit  = wb_q && (wa_q == bus.dst_addr);
        src_data = src_hit ? wd_q : '0;
        dst_data = dst_hit ? wd_q : '0;
        idx      = head;
        for (int i = 0; i < DEPTH; i++) begin
            if (CNT_W'(i) < count) begin
                if (buf_addr[idx] == bus.src_addr) begin
                    src_hit  = 1'b1;
                    src_data = buf_data[idx];
                end
                if (buf_addr[idx] == bus.dst_addr) begin
                    dst_hit  = 1'b1;
                    dst_data = buf_data[idx];
                end
            end
            idx = wrap_inc(idx);
        end
    end

    assign bus.alu_ready    = ready;
    assign bus.write_back   = wb_q;
    assign bus.write_addr   = wa_q;
    assign bus.write_data   = wd_q;
    assign bus.stall_cnt    = stall_q;
    assign bus.fwd_src_hit  = src_hit;
    assign bus.fwd_dst_hit  = dst_hit;
    assign bus.fwd_src_data = src_data;
    assign bus.fwd_dst_data = dst_data;
endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter: priority, buffering, forwarding,
// mid-drain reset and stall counter saturation.
module tb_writeback_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    writeback_arbiter_if #(.DATA_W(16), .ADDR_W(3)) bus ();

    writeback_arbiter #(.DATA_W(16), .ADDR_W(3), .DEPTH(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic mv, input logic [2:0] ma, input logic [15:0] md,
                         input logic av, input logic [2:0] aa, input logic [15:0] ad);
        bus.mem_valid = mv; bus.mem_addr = ma; bus.mem_data = md;
        bus.alu_valid = av; bus.alu_addr = aa; bus.alu_data = ad;
    endtask

    task automatic chk_wb(input string tag, input logic wb, input logic [2:0] a, input logic [15:0] d);
        chk({tag, ".wb"}, bus.write_back, wb);
        chk({tag, ".addr"}, bus.write_addr, a);
        chk({tag, ".data"}, bus.write_data, d);
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0);
        bus.src_addr = 3'd3;
        bus.dst_addr = 3'd5;
        #12;
        // Reset state
        chk_wb("rst", 0, 0, 0);
        chk("rst.ready", bus.alu_ready, 1);
        chk("rst.stall", bus.stall_cnt, 0);
        chk("rst.fsrc", bus.fwd_src_hit, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // ALU only, buffer empty
        drive(0, 0, 0, 1, 3'd3, 16'h000E);
        step();
        chk_wb("alu", 1, 3, 16'h000E);
        chk("alu.ready", bus.alu_ready, 1);
        drive(0, 0, 0, 0, 0, 0);
        step();
        chk_wb("idle", 0, 3, 16'h000E);

        // Collision: mem wins, ALU follows next cycle
        drive(1, 3'd4, 16'h0009, 1, 3'd2, 16'h0001);
        step();
        chk_wb("col.mem", 1, 4, 16'h0009);
        drive(0, 0, 0, 0, 0, 0);
        step();
        chk_wb("col.alu", 1, 2, 16'h0001);
        step();
        chk_wb("col.hold", 0, 2, 16'h0001);

        // Full buffer under continuous mem traffic
        drive(1, 3'd1, 16'h0101, 1, 3'd5, 16'h0A01);
        step();
        chk_wb("full.m1", 1, 1, 16'h0101);
        chk("full.ready1", bus.alu_ready, 1);
        drive(1, 3'd1, 16'h0102, 1, 3'd6, 16'h0A02);
        step();
        chk_wb("full.m2", 1, 1, 16'h0102);
        chk("full.ready0", bus.alu_ready, 0);
        chk("full.stall0", bus.stall_cnt, 0);
        drive(1, 3'd1, 16'h0103, 1, 3'd7, 16'h0A03);
        step();
        chk_wb("full.m3", 1, 1, 16'h0103);
        chk("full.stall1", bus.stall_cnt, 1);
        drive(0, 0, 0, 0, 0, 0);
        step();
        chk_wb("full.d1", 1, 5, 16'h0A01);
        step();
        chk_wb("full.d2", 1, 6, 16'h0A02);
        chk("full.ready", bus.alu_ready, 1);
        step();
        chk_wb("full.empty", 0, 6, 16'h0A02);

        // Forwarding: two buffered writes to r3, newest must win
        drive(1, 3'd1, 16'h0011, 1, 3'd3, 16'h000B);
        step();
        drive(1, 3'd2, 16'h0022, 1, 3'd3, 16'h000F);
        step();
        bus.src_addr = 3'd3;
        bus.dst_addr = 3'd5;
        #1;
        chk("fwd.src_hit", bus.fwd_src_hit, 1);
        chk("fwd.src_data", bus.fwd_src_data, 16'h000F);
        chk("fwd.dst_hit", bus.fwd_dst_hit, 0);
        chk("fwd.dst_data", bus.fwd_dst_data, 0);
        bus.dst_addr = 3'd2;
        #0.5;
        chk("fwd.oreg_hit", bus.fwd_dst_hit, 1);
        chk("fwd.oreg_data", bus.fwd_dst_data, 16'h0022);

        // Reset mid-drain with two entries buffered
        drive(0, 0, 0, 0, 0, 0);
        #1 rst_n = 1'b0;
        #1;
        chk_wb("mid.rst", 0, 0, 0);
        chk("mid.ready", bus.alu_ready, 1);
        chk("mid.fwd", bus.fwd_src_hit, 0);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("mid.nowb", bus.write_back, 0);
        end
        chk("mid.ready2", bus.alu_ready, 1);
        drive(0, 0, 0, 1, 3'd3, 16'h000E);
        step();
        chk_wb("resume", 1, 3, 16'h000E);

        // Stall counter saturation
        drive(1, 3'd1, 16'h1111, 1, 3'd4, 16'h4444);
        step();
        step();
        chk("sat.ready", bus.alu_ready, 0);
        for (int i = 0; i < 254; i++) step();
        chk("sat.254", bus.stall_cnt, 254);
        for (int i = 0; i < 46; i++) step();
        chk("sat.255", bus.stall_cnt, 255);
        drive(0, 0, 0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
